// File: rtl/case_distributor_if.sv
// Handshake and payload bundle for case_distributor: one upstream port fanned out
// to four independently handshaked channels, plus the round-robin and count status.
interface case_distributor_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_sel;
    logic [DATA_W-1:0] in_data;
    logic              rr_mode;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [DATA_W-1:0] out_data3;
    logic [1:0]        rr_ptr;
    logic [7:0]        accept_cnt;

    modport slave (
        input  in_valid, in_sel, in_data, rr_mode, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               rr_ptr, accept_cnt
    );

    modport master (
        output in_valid, in_sel, in_data, rr_mode, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
               rr_ptr, accept_cnt
    );
endinterface

// File: rtl/case_distributor.sv
// Routes each upstream beat into one of four single-entry channel slots, chosen by
// in_sel or by an internal round-robin pointer; slots drain independently.
module case_distributor #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    case_distributor_if.slave bus
);
    logic [3:0]        hv_q, hv_d;
    logic [DATA_W-1:0] hd_q [4];
    logic [DATA_W-1:0] hd_d [4];
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        tgt;
    logic              in_xfer;

    always_comb begin
        tgt          = bus.rr_mode ? rr_ptr_q : bus.in_sel;
        bus.in_ready = !hv_q[tgt] || bus.out_ready[tgt];
        in_xfer      = bus.in_valid && bus.in_ready;
    end

    // A drain and a refill of the same slot in one cycle keeps it valid with new data.
    always_comb begin
        hv_d = hv_q;
        for (int unsigned i = 0; i < 4; i++) begin
            hd_d[i] = hd_q[i];
            if (hv_q[i] && bus.out_ready[i]) begin
                hv_d[i] = 1'b0;
            end
            if (in_xfer && (tgt == 2'(i))) begin
                hv_d[i] = 1'b1;
                hd_d[i] = bus.in_data;
            end
        end
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (in_xfer) begin
            if (bus.rr_mode) begin
                rr_ptr_d = rr_ptr_q + 2'd1;
            end
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hv_q     <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                hd_q[i] <= '0;
            end
        end else begin
            hv_q     <= hv_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            for (int unsigned i = 0; i < 4; i++) begin
                hd_q[i] <= hd_d[i];
            end
        end
    end

    always_comb begin
        bus.out_valid  = hv_q;
        bus.out_data0  = hd_q[0];
        bus.out_data1  = hd_q[1];
        bus.out_data2  = hd_q[2];
        bus.out_data3  = hd_q[3];
        bus.rr_ptr     = rr_ptr_q;
        bus.accept_cnt = cnt_q;
    end
endmodule
